// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one pipeline stage carrying a payload plus control bits,
// with valid/ready handshakes on both sides.
//   SKID=1 : two-entry skid buffer (head + skid). in_ready comes straight from
//            a flop, so there is no combinational path from out_ready to in_ready.
//   SKID=0 : single register. in_ready = !out_valid || out_ready.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   flush                    synchronous kill of every held entry and of the offered beat
//   in_valid/in_ready        upstream handshake; in_data/in_ctrl carry the payload
//   out_valid/out_ready      downstream handshake; out_data/out_ctrl show the head
//   occupancy                number of entries held (0..2)
//   stall_cnt                saturating count of cycles with out_valid=1 and out_ready=0
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t              state_p0, state_nxt;
  logic                vld_p0;
  logic                rdy_p0;
  logic [DATA_W-1:0]   head_data_p0, skid_data_p0;
  logic [CTRL_W-1:0]   head_ctrl_p0, skid_ctrl_p0;
  logic                accept, drain;
  logic                head_ld, head_from_skid, skid_ld;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign vld_p0    = (state_p0 != EMPTY);
  assign out_valid = vld_p0;
  assign occupancy = state_p0;
  assign out_data  = head_data_p0;
  // Stale control bits stay in the head register after a drain; mask them.
  assign out_ctrl  = vld_p0 ? head_ctrl_p0 : '0;
  assign in_ready  = (SKID != 0) ? rdy_p0 : (!vld_p0 || out_ready);

  assign accept = in_valid && in_ready;
  assign drain  = vld_p0 && out_ready;

  // Next state and load enables. With SKID=0 an accept while ONE always
  // coincides with a drain, so TWO is never reached.
  always_comb begin
    state_nxt      = state_p0;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            head_ld   = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head_ld = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            skid_ld   = 1'b1;
          end else if (drain) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_nxt      = ONE;
            head_from_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Stage p0: control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0  <= EMPTY;
      rdy_p0    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state_p0 <= state_nxt;
      rdy_p0   <= (state_nxt != TWO);
      if (vld_p0 && !out_ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  // Stage p0: payload registers, written only on a load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data_p0 <= '0;
      head_ctrl_p0 <= '0;
      skid_data_p0 <= '0;
      skid_ctrl_p0 <= '0;
    end else if (flush) begin
      head_ctrl_p0 <= '0;
      skid_ctrl_p0 <= '0;
    end else begin
      if (head_ld) begin
        head_data_p0 <= in_data;
        head_ctrl_p0 <= in_ctrl;
      end else if (head_from_skid) begin
        head_data_p0 <= skid_data_p0;
        head_ctrl_p0 <= skid_ctrl_p0;
      end
      if (skid_ld) begin
        skid_data_p0 <= in_data;
        skid_ctrl_p0 <= in_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a skid instance (SKID=1) and a
// single-register instance (SKID=0), both DATA_W=8, CTRL_W=4, CNT_W=4.
module tb_pipe_stage_skid;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [1:0]    b_occupancy;
  logic [NW-1:0] b_stall_cnt;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) dut0 (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_ctrl(b_in_ctrl), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl), .occupancy(b_occupancy), .stall_cnt(b_stall_cnt)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] sb0[$];
  int          stall_m;
  bit          rst_fresh;
  bit          hold_prev;
  logic [DW-1:0] prev_data;
  logic [CW-1:0] prev_ctrl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check one cycle at the falling edge, update the scoreboards with the
  // transfers that the next rising edge will perform, then step past it.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    chk("occupancy", occupancy, sb.size());
    chk("out_valid", out_valid, sb.size() != 0);
    chk("in_ready", in_ready, rst_fresh ? 0 : (sb.size() < 2));
    chk("stall_cnt", stall_cnt, stall_m);
    if (!out_valid) chk("ctrl_idle", out_ctrl, 0);
    if (hold_prev) begin
      chk("hold_data", out_data, prev_data);
      chk("hold_ctrl", out_ctrl, prev_ctrl);
    end
    hold_prev = out_valid && !out_ready && !flush;
    prev_data = out_data;
    prev_ctrl = out_ctrl;
    if (out_valid && !out_ready && stall_m < 15) stall_m++;
    if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_beat", {out_ctrl, out_data}, e);
      end
      if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
    end

    chk("b_occupancy", b_occupancy, sb0.size());
    chk("b_out_valid", b_out_valid, sb0.size() != 0);
    chk("b_in_ready", b_in_ready, (sb0.size() == 0) || b_out_ready);
    if (!b_out_valid) chk("b_ctrl_idle", b_out_ctrl, 0);
    if (b_out_valid && b_out_ready && sb0.size() != 0) begin
      e = sb0.pop_front();
      chk("b_out_beat", {b_out_ctrl, b_out_data}, e);
    end
    if (b_in_valid && b_in_ready) sb0.push_back({b_in_ctrl, b_in_data});
    @(posedge clk);
    #1;
    rst_fresh = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_ctrl = '0; b_out_ready = 1'b0;
    stall_m = 0; hold_prev = 1'b0; rst_fresh = 1'b0;
    prev_data = '0; prev_ctrl = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    rst_fresh = 1'b1;
    tick();
    tick();

    // Back-to-back stream 1..8 with out_ready held high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      in_ctrl  = CW'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();

    // Fill both entries while the downstream stalls, then drain
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA; in_ctrl = 4'h5;
    tick();
    in_data = 8'hBB; in_ctrl = 4'h6;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("skid_head", out_data, 8'hAA);
    out_ready = 1'b1;
    repeat (3) tick();

    // Stall counter saturation with one held beat
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h3C; in_ctrl = 4'h7;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("stall_sat", stall_cnt, 15);

    // Flush while full, with a beat offered
    in_valid = 1'b1; in_data = 8'h44; in_ctrl = 4'h9;
    tick();
    flush = 1'b1; in_data = 8'hCC; in_ctrl = 4'hF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occupancy", occupancy, 0);
    chk("flush_out_ctrl", out_ctrl, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_keeps_stall", stall_cnt, 15);
    out_ready = 1'b1;
    repeat (3) tick();

    // Flush while holding one entry: the accepted-looking beat is dropped
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; in_ctrl = 4'h3;
    tick();
    flush = 1'b1; in_data = 8'h66; in_ctrl = 4'h4;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();

    // Reset mid-stream with two entries held
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h71; in_ctrl = 4'h1;
    tick();
    in_data = 8'h72; in_ctrl = 4'h2;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_ctrl", out_ctrl, 0);
    chk("mid_rst_occupancy", occupancy, 0);
    chk("mid_rst_stall_cnt", stall_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    sb.delete(); sb0.delete();
    stall_m = 0; hold_prev = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rst_fresh = 1'b1;
    out_ready = 1'b1;
    repeat (4) tick();
    in_valid = 1'b1; in_data = 8'h81; in_ctrl = 4'hA;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();

    // SKID=0: drain and accept in the same cycle
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_data = 8'h10; b_in_ctrl = 4'h1;
    tick();
    b_out_ready = 1'b0;
    b_in_data = 8'h20; b_in_ctrl = 4'h2;
    tick();
    b_out_ready = 1'b1;
    #1;
    chk("b_ready_same_cycle", b_in_ready, 1);
    tick();
    b_in_valid = 1'b0;
    chk("b_head_replaced", b_out_data, 8'h20);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
